// File: rtl/rle_pkg.sv
// Shared types and helpers for the run-length stream decompressor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rle_pkg;

    // Decoder phase: waiting for a frame header, decoding runs, or
    // presenting the flushed last word of a frame.
    typedef enum logic [1:0] {
        HDR   = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rle_state_e;

    // Default packed output width and the matching fill counter width.
    // The fill counter needs one extra bit so that it can hold OUT_W itself.
    localparam int OUT_W_DEFAULT = 16;
    localparam int FILL_W        = $clog2(OUT_W_DEFAULT) + 1;

    // Unsigned minimum, used to clip a run against the room left in a word.
    function automatic logic [31:0] min_u(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/rle_bit_packer.sv
// Forces bits [fill, fill+n) of a word to cur_bit, leaving the rest untouched.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module rle_bit_packer
    import rle_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = OUT_W_DEFAULT,
    parameter int FW    = FILL_W
) (
    input  logic [FW-1:0]    fill,
    input  logic [IN_W-1:0]  n,
    input  logic             cur_bit,
    input  logic [OUT_W-1:0] word_in,
    output logic [OUT_W-1:0] word_out
);

    // Bounds of the bit window, one bit wider than needed so fill+n never wraps.
    logic [32:0] lo;
    logic [32:0] hi;

    assign lo = 33'(fill);
    assign hi = 33'(fill) + 33'(n);

    // Overwrite every bit position that falls inside the window.
    always_comb begin
        word_out = word_in;
        for (int i = 0; i < OUT_W; i++) begin
            if ((33'(i) >= lo) && (33'(i) < hi)) begin
                word_out[i] = cur_bit;
            end
        end
    end

endmodule

// File: rtl/rle_stream_decompressor.sv
// Run-length decoder: header word sets the first bit value, each later word is a run length; bits are packed LSB-first.
// Latency: a run accepted at edge E contributes its first bits to out_data at E+1; a full word is valid after that edge.
// Backpressure: out_valid && !out_ready freezes all state; in_ready drops while a run drains, a word waits, or a flush is pending.
module rle_stream_decompressor
    import rle_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = OUT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int FW = $clog2(OUT_W) + 1;

    rle_state_e       state_q,      state_d;
    logic [IN_W-1:0]  remaining_q,  remaining_d;
    logic [FW-1:0]    fill_q,       fill_d;
    logic             cur_bit_q,    cur_bit_d;
    logic             flush_pend_q, flush_pend_d;
    logic [OUT_W-1:0] out_data_q,   out_data_d;
    logic             out_valid_q,  out_valid_d;
    logic             out_last_q,   out_last_d;

    logic [31:0]      space;
    logic [IN_W-1:0]  n;
    logic [IN_W-1:0]  rem_next;
    logic [FW-1:0]    fill_next;
    logic [OUT_W-1:0] packed_word;
    logic             accept;

    // Bits that fit in this step: the smaller of what the run still owes and the room left in the word.
    assign space     = 32'(OUT_W) - 32'(fill_q);
    assign n         = IN_W'(min_u(32'(remaining_q), space));
    assign rem_next  = remaining_q - n;
    assign fill_next = fill_q + FW'(n);

    // The input is only taken when nothing else is in flight, so an accept never
    // collides with a fill step, a waiting output word or a flush drain.
    assign in_ready = !rst &&
                      ((state_q == HDR) ||
                       ((state_q == RUN) && (remaining_q == '0) && !out_valid_q && !flush_pend_q));
    assign accept   = in_valid && in_ready;

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != HDR) || out_valid_q;

    rle_bit_packer #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .FW    (FW)
    ) u_packer (
        .fill     (fill_q),
        .n        (n),
        .cur_bit  (cur_bit_q),
        .word_in  (out_data_q),
        .word_out (packed_word)
    );

    // Next-state logic: soft restart, output handshake, fill step, flush drain and input accept.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        fill_d       = fill_q;
        cur_bit_d    = cur_bit_q;
        flush_pend_d = flush_pend_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;

        if (start) begin
            // Drop everything, including a partially filled word and a pending flush.
            state_d      = HDR;
            remaining_d  = '0;
            fill_d       = '0;
            cur_bit_d    = 1'b0;
            flush_pend_d = 1'b0;
            out_data_d   = '0;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
        end else begin
            // A flush request is only meaningful while decoding runs.
            if (flush && (state_q == RUN)) begin
                flush_pend_d = 1'b1;
            end

            // Word taken by the consumer; clearing out_data leaves the next word's padding at zero.
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                out_data_d  = '0;
                if (state_q == FLUSH) begin
                    state_d      = HDR;
                    flush_pend_d = 1'b0;
                end
            end

            if ((remaining_q != '0) && !out_valid_q) begin
                // Pour as much of the current run into the word as fits.
                out_data_d  = packed_word;
                remaining_d = rem_next;
                if (rem_next == '0) begin
                    cur_bit_d = ~cur_bit_q;
                end
                if (fill_next == FW'(OUT_W)) begin
                    out_valid_d = 1'b1;
                    fill_d      = '0;
                end else begin
                    fill_d = fill_next;
                end
            end else if ((state_q == RUN) && flush_pend_q && (remaining_q == '0) && !out_valid_q) begin
                // Runs have drained: emit the partial word, or end the frame silently if empty.
                if (fill_q != '0) begin
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                    fill_d      = '0;
                    state_d     = FLUSH;
                end else begin
                    state_d      = HDR;
                    flush_pend_d = 1'b0;
                end
            end

            if (accept) begin
                if (state_q == HDR) begin
                    cur_bit_d = in_data[0];
                    state_d   = RUN;
                end else if (in_data == '0) begin
                    // Zero-length run: flip polarity so two runs of one value can be chained.
                    cur_bit_d = ~cur_bit_q;
                end else begin
                    remaining_d = in_data;
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HDR;
            remaining_q  <= '0;
            fill_q       <= '0;
            cur_bit_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            fill_q       <= fill_d;
            cur_bit_q    <= cur_bit_d;
            flush_pend_q <= flush_pend_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
        end
    end

endmodule

// File: tb/tb_rle_stream_decompressor.sv
// Directed bench for the run-length decompressor with OUT_W = IN_W = 16.
// Latency: n/a.
// Backpressure: consumer ready is held low except for a single handshake cycle per expected word.
module tb_rle_stream_decompressor;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    int n_run;
    int n_fail;

    rle_stream_decompressor #(
        .IN_W  (16),
        .OUT_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one input word and hold it until the edge that accepts it.
    task automatic send(input logic [15:0] w);
        int cnt;
        cnt      = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && cnt < 200) begin
            tick();
            cnt++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Wait for a word, check it, then complete one handshake.
    task automatic expect_word(input string tag, input logic [15:0] exp_data, input logic exp_last);
        int cnt;
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            tick();
            cnt++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(exp_data));
        chk({tag, "_last"},  32'(out_last),  32'(exp_last));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_taken"}, 32'(out_valid), 32'd0);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        n_run     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Header 1, runs 3,5,8 -> 0xFF07
        send(16'h0001);
        send(16'd3);
        chk("t1_busy_run", 32'(in_ready), 32'd0);
        send(16'd5);
        send(16'd8);
        expect_word("t1_word", 16'hFF07, 1'b0);
        chk("t1_ready_again", 32'(in_ready), 32'd1);
        pulse_flush();
        tick();
        chk("t1_end_busy",  32'(busy),      32'd0);
        chk("t1_end_nowrd", 32'(out_valid), 32'd0);

        // Header 0, runs 40, 8 -> 0x0000, 0x0000, 0xFF00
        send(16'h0000);
        send(16'd40);
        chk("t2_ready_40a", 32'(in_ready), 32'd0);
        expect_word("t2_w0", 16'h0000, 1'b0);
        chk("t2_ready_40b", 32'(in_ready), 32'd0);
        expect_word("t2_w1", 16'h0000, 1'b0);
        send(16'd8);
        expect_word("t2_w2", 16'hFF00, 1'b0);
        pulse_flush();
        tick();
        chk("t2_end_busy", 32'(busy), 32'd0);

        // Header 1, runs 4,0,4, flush -> 0x00FF last
        send(16'h0001);
        send(16'd4);
        send(16'd0);
        send(16'd4);
        pulse_flush();
        expect_word("t3_word", 16'h00FF, 1'b1);
        chk("t3_hdr_busy",  32'(busy),     32'd0);
        chk("t3_hdr_ready", 32'(in_ready), 32'd1);

        // Run 16 then 16 with the consumer stalled for 5 cycles
        send(16'h0001);
        send(16'd16);
        tick();
        chk("t4_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_data",  32'(out_data), 32'hFFFF);
            chk("t4_hold_ready", 32'(in_ready), 32'd0);
            tick();
        end
        expect_word("t4_w0", 16'hFFFF, 1'b0);
        chk("t4_ready_after", 32'(in_ready), 32'd1);
        send(16'd16);
        expect_word("t4_w1", 16'h0000, 1'b0);
        pulse_flush();
        tick();
        chk("t4_end_busy", 32'(busy), 32'd0);

        // Soft restart after 5 bits filled
        send(16'h0000);
        send(16'd5);
        tick();
        chk("t5_pre_busy",  32'(busy),      32'd1);
        chk("t5_pre_valid", 32'(out_valid), 32'd0);
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        chk("t5_ready", 32'(in_ready),  32'd1);
        chk("t5_busy",  32'(busy),      32'd0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_data",  32'(out_data),  32'd0);
        send(16'h0000);
        send(16'd16);
        expect_word("t5_word", 16'h0000, 1'b0);
        pulse_flush();
        tick();

        // Async reset with remaining = 20 while a word waits
        send(16'h0001);
        send(16'd36);
        tick();
        chk("t6_valid", 32'(out_valid), 32'd1);
        chk("t6_data",  32'(out_data),  32'hFFFF);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_data",  32'(out_data),  32'd0);
        chk("t6_rst_last",  32'(out_last),  32'd0);
        chk("t6_rst_ready", 32'(in_ready),  32'd0);
        chk("t6_rst_busy",  32'(busy),      32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("t6_rel_ready", 32'(in_ready), 32'd1);
        send(16'h0000);
        send(16'd16);
        expect_word("t6_word", 16'h0000, 1'b0);
        send(16'd16);
        expect_word("t6_word2", 16'hFFFF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/rle_stream_decompressor.md
Name: rle_stream_decompressor

Overview:
- Parametrised run-length decompressor for the DCNN accelerator input path.
- Input is a stream of words. The first word of a frame is a header whose bit 0 is the initial bit value. Every later word is a run length of consecutive identical bits; the bit value inverts after each run.
- Decoded bits are packed LSB-first into OUT_W-bit words and delivered on a valid/ready interface to the DMA/buffer side.
- Improvements over the previous fixed 16-bit decompressor: valid/ready handshakes on both sides, runs spanning any number of output words, zero-length runs, soft restart, and frame flush with a padded partial last word.

Parameters:
- IN_W, 16, width of input words (header and run-length count).
- OUT_W, 16, width of packed output word; must be ≥ 2.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  synchronous soft restart (replaces the old interrupt); discards all state, returns to HDR.
- flush  in  1  end-of-frame pulse; emits the partial word and returns to HDR.
- in_data  in  IN_W  header or run-length word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  OUT_W  packed decoded bits, bit 0 = earliest bit.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts out_data.
- out_last  out  1  qualifies out_valid; word is the final (flushed) word of a frame.
- busy  out  1  state ≠ HDR, or out_valid high.

Behaviour:
- Reset (rst high, async):
  - state=HDR; remaining=0; fill=0; cur_bit=0; flush_pend=0.
  - out_data=0, out_valid=0, out_last=0, in_ready deasserts while rst is high.
- start (sync, priority over everything except rst): same register values as reset; the in-flight word and partial fill are discarded. in_ready is high in the next cycle.
- States: HDR, RUN, FLUSH (package enum).
- in_ready (combinational from registers only, never from inputs):
  - high when state==HDR, or state==RUN && remaining==0 && !out_valid && !flush_pend.
  - A word is accepted on an edge where in_valid && in_ready.
- HDR accept: cur_bit ← in_data[0]; state ← RUN.
- RUN accept with in_data==0: cur_bit inverts; no bits produced. A chain such as max, 0, max builds runs longer than 2^IN_W−1.
- RUN accept with in_data≠0: remaining ← in_data. Bit production starts on the next edge.
- Fill step, each edge with remaining>0 && !out_valid:
  - n = min(remaining, OUT_W−fill).
  - Set out_data[fill .. fill+n−1] = cur_bit.
  - remaining −= n; fill += n.
  - If remaining becomes 0: cur_bit inverts on the same edge.
  - If fill becomes OUT_W: out_valid←1, fill←0.
- Latency examples:
  - Run of 16 accepted at edge E (OUT_W=16): out_valid is high after E+1.
  - in_ready returns high the cycle after the edge where remaining hits 0, provided no word is pending.
- Output handshake:
  - On out_valid && out_ready: out_valid←0, out_last←0, out_data←0. Filling resumes on the following edge.
  - While out_valid && !out_ready: out_data, out_last and all state are held; no fill and no input accept.
- flush:
  - A flush pulse in RUN sets flush_pend, including in the same cycle as a run accept. That run drains first.
  - When state==RUN && flush_pend && remaining==0 && !out_valid:
    - if fill>0: out_valid←1, out_last←1, unfilled bits=0, state←FLUSH.
    - else: state←HDR directly, with no output word.
  - FLUSH waits for the out handshake, then moves to HDR and clears flush_pend.
  - flush in HDR or FLUSH is ignored.
- Arithmetic: remaining is IN_W bits; fill is clog2(OUT_W)+1 bits; n is computed at IN_W width with no truncation.
- Simultaneous start and flush: start wins and flush is dropped.

Decomposition:
- Package rle_pkg: state enum (HDR, RUN, FLUSH), helper function min_u, localparam FILL_W = $clog2(OUT_W)+1.
- Sub-module rle_bit_packer: combinational mask generator. Inputs: fill, n, cur_bit, current word. Output: the updated word, with bits [fill, fill+n) forced to cur_bit.

Test Plan:
- OUT_W=16; header 0x0001, runs 3,5,8 → one word 0xFF07, out_last=0; in_ready high again after the run of 8 drains.
- Header 0x0000, runs 40, 8 → words 0x0000, 0x0000, 0xFF00; no input accepted while the 40-run drains.
- Header 0x0001, runs 4, 0, 4, then flush → one word 0x00FF with out_last=1; state returns to HDR; next word is treated as a header.
- Run 16 then run 16 with out_ready low for 5 cycles after the first out_valid → out_data stays stable; in_ready low throughout; second word is delivered only after the handshake.
- After 5 bits are filled, pulse start → no output word; in_ready=1 next cycle; header 0x0000 and run 16 → 0x0000.
- Assert rst asynchronously mid-run with remaining=20 → all outputs 0 immediately; after release, decoding restarts at HDR.
